// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared opcode and ALUOp encodings, the packed control bundle
//               and the opcode-to-control decode function for decode_stage_p.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    // Opcode field values (instruction[15:13])
    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_LW    = 3'b001;
    localparam logic [2:0] OP_SW    = 3'b010;
    localparam logic [2:0] OP_BEQ   = 3'b011;
    localparam logic [2:0] OP_ADDI  = 3'b100;

    // ALUOp encodings handed to the ALU control unit
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // Control bundle carried through ID/EX; a bubble is simply all-zero
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Map an opcode to its control bundle; unused opcodes decode as NOP
    function automatic ctrl_t decode_ctrl(input logic [2:0] opcode);
        ctrl_t c_ctrl;
        c_ctrl = CTRL_BUBBLE;
        case (opcode)
            OP_RTYPE: begin
                c_ctrl.reg_dst   = 1'b1;
                c_ctrl.reg_write = 1'b1;
                c_ctrl.alu_op    = ALUOP_RTYPE;
            end
            OP_LW: begin
                c_ctrl.alu_src    = 1'b1;
                c_ctrl.mem_to_reg = 1'b1;
                c_ctrl.reg_write  = 1'b1;
                c_ctrl.mem_read   = 1'b1;
                c_ctrl.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                c_ctrl.alu_src   = 1'b1;
                c_ctrl.mem_write = 1'b1;
                c_ctrl.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                c_ctrl.branch = 1'b1;
                c_ctrl.alu_op = ALUOP_SUB;
            end
            OP_ADDI: begin
                c_ctrl.alu_src   = 1'b1;
                c_ctrl.reg_write = 1'b1;
                c_ctrl.alu_op    = ALUOP_ADD;
            end
            default: c_ctrl = CTRL_BUBBLE;
        endcase
        return c_ctrl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_p_register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file_p
// Description : 8-entry register file, two combinational read ports, one
//               rising-edge write port, asynchronous clear. Register 0 is an
//               ordinary writable register.
//               Optional macro DECODE_BYPASS_EN: a same-cycle write to the
//               address being read is forwarded to that read port.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_p #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [2:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [2:0]        i_raddr1,
    input  logic [2:0]        i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);
    import decode_pkg::*;

    localparam int c_DEPTH = 8;

    logic [DATA_W-1:0] r_regs [c_DEPTH];

    // Storage: cleared asynchronously, written on the rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

`ifdef DECODE_BYPASS_EN
    // Read ports with per-port forwarding of a same-cycle writeback
    always_comb begin
        o_rdata1 = r_regs[i_raddr1];
        o_rdata2 = r_regs[i_raddr2];
        if (i_we && (i_waddr == i_raddr1)) begin
            o_rdata1 = i_wdata;
        end
        if (i_we && (i_waddr == i_raddr2)) begin
            o_rdata2 = i_wdata;
        end
    end
`else
    // Read ports return the pre-write contents during a same-cycle write
    always_comb begin
        o_rdata1 = r_regs[i_raddr1];
        o_rdata2 = r_regs[i_raddr2];
    end
`endif

endmodule
`default_nettype wire

// File: rtl/decode_stage_p.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_p
// Description : Registered decode stage. Decodes a 16-bit instruction, reads
//               rs/rt from the register file, sign-extends the immediate and
//               captures everything in the ID/EX register. Detects load-use
//               hazards (combinational stall) and inserts bubbles on stall,
//               flush or an invalid incoming slot.
//               Optional macro DECODE_BYPASS_EN: register-file write-to-read
//               forwarding within the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage_p
    import decode_pkg::*;
#(
    parameter int DATA_W   = 16,  // >= 8
    parameter int IMM_W    = 7,   // <= 10
    parameter int RF_DEPTH = 8    // fixed by the 3-bit register fields
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instruction,
    input  logic              id_valid,
    input  logic              flush,
    input  logic              wb_reg_write,
    input  logic [2:0]        wb_write_register,
    input  logic [DATA_W-1:0] wb_write_data,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_read_data_1,
    output logic [DATA_W-1:0] ex_read_data_2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [2:0]        ex_rs,
    output logic [2:0]        ex_rt,
    output logic [2:0]        ex_rd,
    output logic [1:0]        ex_alu_op,
    output logic              ex_reg_dst,
    output logic              ex_alu_src,
    output logic              ex_mem_to_reg,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch
);

    localparam int c_RF_AW = $clog2(RF_DEPTH);

    // Instruction fields
    logic [2:0]         w_opcode;
    logic [c_RF_AW-1:0] w_rs;
    logic [c_RF_AW-1:0] w_rt;
    logic [c_RF_AW-1:0] w_rd;
    logic [DATA_W-1:0]  w_imm;
    logic [DATA_W-1:0]  w_rdata1;
    logic [DATA_W-1:0]  w_rdata2;
    ctrl_t              w_ctrl;
    logic               w_stall;
    logic               w_bubble;

    // ID/EX pipeline register
    logic               r_ex_valid;
    ctrl_t              r_ex_ctrl;
    logic [DATA_W-1:0]  r_ex_rdata1;
    logic [DATA_W-1:0]  r_ex_rdata2;
    logic [DATA_W-1:0]  r_ex_imm;
    logic [c_RF_AW-1:0] r_ex_rs;
    logic [c_RF_AW-1:0] r_ex_rt;
    logic [c_RF_AW-1:0] r_ex_rd;

    assign w_opcode = instruction[15:13];
    assign w_rs     = instruction[12:10];
    assign w_rt     = instruction[9:7];
    assign w_rd     = instruction[6:4];

    register_file_p #(
        .DATA_W (DATA_W)
    ) u_register_file (
        .clk      (clk),
        .rst      (rst),
        .i_we     (wb_reg_write),
        .i_waddr  (wb_write_register),
        .i_wdata  (wb_write_data),
        .i_raddr1 (w_rs),
        .i_raddr2 (w_rt),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2)
    );

    // Decode, sign extension and load-use hazard detection
    always_comb begin
        w_ctrl   = decode_ctrl(w_opcode);
        w_imm    = {{(DATA_W-IMM_W){instruction[IMM_W-1]}}, instruction[IMM_W-1:0]};
        w_stall  = id_valid & r_ex_valid & r_ex_ctrl.mem_read &
                   ((r_ex_rt == w_rs) | (r_ex_rt == w_rt));
        // flush does not suppress stall; fetch resolves that itself
        w_bubble = flush | w_stall | ~id_valid;
    end

    // ID/EX capture: bubble (all zero) or the decoded instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid  <= 1'b0;
            r_ex_ctrl   <= CTRL_BUBBLE;
            r_ex_rdata1 <= '0;
            r_ex_rdata2 <= '0;
            r_ex_imm    <= '0;
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_ex_rd     <= '0;
        end else if (w_bubble) begin
            r_ex_valid  <= 1'b0;
            r_ex_ctrl   <= CTRL_BUBBLE;
            r_ex_rdata1 <= '0;
            r_ex_rdata2 <= '0;
            r_ex_imm    <= '0;
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_ex_rd     <= '0;
        end else begin
            r_ex_valid  <= 1'b1;
            r_ex_ctrl   <= w_ctrl;
            r_ex_rdata1 <= w_rdata1;
            r_ex_rdata2 <= w_rdata2;
            r_ex_imm    <= w_imm;
            r_ex_rs     <= w_rs;
            r_ex_rt     <= w_rt;
            r_ex_rd     <= w_rd;
        end
    end

    assign stall          = w_stall;
    assign ex_valid       = r_ex_valid;
    assign ex_read_data_1 = r_ex_rdata1;
    assign ex_read_data_2 = r_ex_rdata2;
    assign ex_imm         = r_ex_imm;
    assign ex_rs          = r_ex_rs;
    assign ex_rt          = r_ex_rt;
    assign ex_rd          = r_ex_rd;
    assign ex_alu_op      = r_ex_ctrl.alu_op;
    assign ex_reg_dst     = r_ex_ctrl.reg_dst;
    assign ex_alu_src     = r_ex_ctrl.alu_src;
    assign ex_mem_to_reg  = r_ex_ctrl.mem_to_reg;
    assign ex_reg_write   = r_ex_ctrl.reg_write;
    assign ex_mem_read    = r_ex_ctrl.mem_read;
    assign ex_mem_write   = r_ex_ctrl.mem_write;
    assign ex_branch      = r_ex_ctrl.branch;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage_p
// Description : Directed self-checking bench for decode_stage_p.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage_p;

    localparam int DATA_W = 16;

    logic              clk;
    logic              rst;
    logic [15:0]       instruction;
    logic              id_valid;
    logic              flush;
    logic              wb_reg_write;
    logic [2:0]        wb_write_register;
    logic [DATA_W-1:0] wb_write_data;
    logic              stall;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_read_data_1;
    logic [DATA_W-1:0] ex_read_data_2;
    logic [DATA_W-1:0] ex_imm;
    logic [2:0]        ex_rs;
    logic [2:0]        ex_rt;
    logic [2:0]        ex_rd;
    logic [1:0]        ex_alu_op;
    logic              ex_reg_dst;
    logic              ex_alu_src;
    logic              ex_mem_to_reg;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_branch;

    int checks;
    int failures;

    decode_stage_p #(
        .DATA_W   (DATA_W),
        .IMM_W    (7),
        .RF_DEPTH (8)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .instruction       (instruction),
        .id_valid          (id_valid),
        .flush             (flush),
        .wb_reg_write      (wb_reg_write),
        .wb_write_register (wb_write_register),
        .wb_write_data     (wb_write_data),
        .stall             (stall),
        .ex_valid          (ex_valid),
        .ex_read_data_1    (ex_read_data_1),
        .ex_read_data_2    (ex_read_data_2),
        .ex_imm            (ex_imm),
        .ex_rs             (ex_rs),
        .ex_rt             (ex_rt),
        .ex_rd             (ex_rd),
        .ex_alu_op         (ex_alu_op),
        .ex_reg_dst        (ex_reg_dst),
        .ex_alu_src        (ex_alu_src),
        .ex_mem_to_reg     (ex_mem_to_reg),
        .ex_reg_write      (ex_reg_write),
        .ex_mem_read       (ex_mem_read),
        .ex_mem_write      (ex_mem_write),
        .ex_branch         (ex_branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one decode slot at a negedge (no writeback), then wait to the next negedge
    task automatic issue(input logic [15:0] instr, input logic valid, input logic fl);
        instruction  = instr;
        id_valid     = valid;
        flush        = fl;
        wb_reg_write = 1'b0;
        @(negedge clk);
    endtask

    // Write a register through the writeback port with decode idle
    task automatic wb_write(input logic [2:0] addr, input logic [15:0] data);
        id_valid          = 1'b0;
        flush             = 1'b0;
        wb_reg_write      = 1'b1;
        wb_write_register = addr;
        wb_write_data     = data;
        @(negedge clk);
        wb_reg_write      = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset asserted with busy, non-zero inputs
        rst               = 1'b1;
        instruction       = 16'h2500;  // lw rs=1 rt=2
        id_valid          = 1'b1;
        flush             = 1'b0;
        wb_reg_write      = 1'b1;
        wb_write_register = 3'd3;
        wb_write_data     = 16'hAAAA;
        #1;
        check("rst_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        check("rst_regwrite", {31'd0, ex_reg_write}, 32'd0);
        check("rst_memread", {31'd0, ex_mem_read}, 32'd0);
        check("rst_rd1", {16'd0, ex_read_data_1}, 32'd0);
        wb_reg_write = 1'b0;
        rst          = 1'b0;

        // r3 reads 0 after reset (write during reset was ignored)
        issue(16'h0C00, 1'b1, 1'b0);  // add rs=3
        check("r3_zero", {16'd0, ex_read_data_1}, 32'd0);
        check("r3_valid", {31'd0, ex_valid}, 32'd1);

        // R-type add rd=3, rs=1, rt=2
        wb_write(3'd1, 16'h0005);
        wb_write(3'd2, 16'h0003);
        issue(16'h0530, 1'b1, 1'b0);
        check("add_valid", {31'd0, ex_valid}, 32'd1);
        check("add_regdst", {31'd0, ex_reg_dst}, 32'd1);
        check("add_regwrite", {31'd0, ex_reg_write}, 32'd1);
        check("add_aluop", {30'd0, ex_alu_op}, 32'd2);
        check("add_alusrc", {31'd0, ex_alu_src}, 32'd0);
        check("add_rd1", {16'd0, ex_read_data_1}, 32'h0005);
        check("add_rd2", {16'd0, ex_read_data_2}, 32'h0003);
        check("add_rd", {29'd0, ex_rd}, 32'd3);

        // addi sign extension, negative and positive immediates
        issue(16'h807F, 1'b1, 1'b0);
        check("addi_neg_imm", {16'd0, ex_imm}, 32'h0000FFFF);
        check("addi_alusrc", {31'd0, ex_alu_src}, 32'd1);
        check("addi_regdst", {31'd0, ex_reg_dst}, 32'd0);
        check("addi_aluop", {30'd0, ex_alu_op}, 32'd0);
        issue(16'h803F, 1'b1, 1'b0);
        check("addi_pos_imm", {16'd0, ex_imm}, 32'h0000003F);

        // beq decodes branch with ALUOp 01
        issue(16'h6500, 1'b1, 1'b0);
        check("beq_branch", {31'd0, ex_branch}, 32'd1);
        check("beq_aluop", {30'd0, ex_alu_op}, 32'd1);

        // Load-use: lw rt=2 followed by add rs=2 rt=1 rd=4
        issue(16'h2500, 1'b1, 1'b0);
        check("lw_memread", {31'd0, ex_mem_read}, 32'd1);
        check("lw_memtoreg", {31'd0, ex_mem_to_reg}, 32'd1);
        instruction = 16'h08C0;
        #1;
        check("lu_stall_hi", {31'd0, stall}, 32'd1);
        @(negedge clk);
        check("lu_bubble", {31'd0, ex_valid}, 32'd0);
        check("lu_bubble_rw", {31'd0, ex_reg_write}, 32'd0);
        check("lu_stall_lo", {31'd0, stall}, 32'd0);
        @(negedge clk);
        check("lu_dep_valid", {31'd0, ex_valid}, 32'd1);
        check("lu_dep_rs", {29'd0, ex_rs}, 32'd2);
        check("lu_dep_rd", {29'd0, ex_rd}, 32'd4);
        check("lu_dep_rd1", {16'd0, ex_read_data_1}, 32'h0003);
        check("lu_dep_rd2", {16'd0, ex_read_data_2}, 32'h0005);

        // Flush of a valid sw, then the next sw goes through
        issue(16'h4500, 1'b1, 1'b1);
        check("flush_valid", {31'd0, ex_valid}, 32'd0);
        check("flush_memwrite", {31'd0, ex_mem_write}, 32'd0);
        issue(16'h4500, 1'b1, 1'b0);
        check("sw_valid", {31'd0, ex_valid}, 32'd1);
        check("sw_memwrite", {31'd0, ex_mem_write}, 32'd1);
        check("sw_regwrite", {31'd0, ex_reg_write}, 32'd0);

        // Bubble input
        issue(16'h0530, 1'b0, 1'b0);
        check("idle_valid", {31'd0, ex_valid}, 32'd0);

        // Same-cycle writeback and read of r4
        wb_write(3'd4, 16'h1234);
        instruction       = 16'h1000;  // add rs=4
        id_valid          = 1'b1;
        flush             = 1'b0;
        wb_reg_write      = 1'b1;
        wb_write_register = 3'd4;
        wb_write_data     = 16'hBEEF;
        @(negedge clk);
        wb_reg_write = 1'b0;
`ifdef DECODE_BYPASS_EN
        check("bypass_rd1", {16'd0, ex_read_data_1}, 32'h0000BEEF);
`else
        check("bypass_rd1", {16'd0, ex_read_data_1}, 32'h00001234);
`endif
        issue(16'h1000, 1'b1, 1'b0);
        check("r4_after", {16'd0, ex_read_data_1}, 32'h0000BEEF);

        // Mid-operation asynchronous reset while a load-use stall is active
        issue(16'h2500, 1'b1, 1'b0);
        instruction = 16'h08C0;
        #1;
        check("mid_stall_hi", {31'd0, stall}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
        check("mid_rst_memread", {31'd0, ex_mem_read}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(16'h0400, 1'b1, 1'b0);  // add rs=1
        check("mid_rst_r1", {16'd0, ex_read_data_1}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
